// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Number of DIGIT-wide slices needed to cover WIDTH bits.
    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter width able to hold NUM_DIGITS-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int SUB_WIDTH_DEF = 32;
    localparam int SUB_DIGIT_DEF = 4;
    localparam int SUB_CNT_W_DEF = cnt_width(num_digits(SUB_WIDTH_DEF, SUB_DIGIT_DEF));

endpackage

// File: rtl/serial_subtractor_slice.sv
// One DIGIT-bit ripple slice: s/cout = a + b_inv + cin.
// Subtraction is obtained by feeding the inverted subtrahend and a carry of ~borrow.
module digit_sub_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b_inv,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    logic [DIGIT:0] sum;

    // Widen by one bit so the carry-out falls out of the add.
    assign sum       = {1'b0, a} + {1'b0, b_inv} + {{DIGIT{1'b0}}, cin};
    assign {cout, s} = sum;

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial two's-complement subtractor: Diff = A - B - Bin, DIGIT bits per cycle.
// Optional feature macro: SERIAL_SUB_OVF_EN enables the signed overflow flag;
// without it overflow is tied low and the operand sign bits are not stored.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             overflow
);

    localparam int NUM_DIGITS = num_digits(WIDTH, DIGIT);
    localparam int CNT_W      = cnt_width(NUM_DIGITS);

    generate
        if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("serial_subtractor: DIGIT must divide WIDTH");
        end
    endgenerate

    sub_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;     // holds ~B, consumed LSB digit first
    logic             carry;
    logic [WIDTH-1:0] res_sh;   // partial result, filled from the top
    logic [WIDTH-1:0] res_nx;
    logic [DIGIT-1:0] s;
    logic             cout;
    logic             last_digit;

    assign last_digit = (cnt == '0);
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);

    // New digit enters at the top; after NUM_DIGITS shifts the LSB digit sits at bit 0.
    assign res_nx = WIDTH'({s, res_sh} >> DIGIT);

    digit_sub_slice #(.DIGIT(DIGIT)) u_slice (
        .a     (a_sh[DIGIT-1:0]),
        .b_inv (b_sh[DIGIT-1:0]),
        .cin   (carry),
        .s     (s),
        .cout  (cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state: accept in IDLE, count digits in RUN, wait for the consumer in DONE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)   state_nx = RUN;
            RUN:     if (last_digit) state_nx = DONE;
            DONE:    if (out_ready)  state_nx = IDLE;
            default:                 state_nx = IDLE;
        endcase
    end

    // Datapath: load operands on accept, ripple one digit per RUN cycle,
    // and publish Diff/Bout only on the final digit so outputs stay stable otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            res_sh <= '0;
            Diff   <= '0;
            Bout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= A;
                        b_sh  <= ~B;
                        carry <= ~Bin;
                        cnt   <= CNT_W'(NUM_DIGITS - 1);
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    carry  <= cout;
                    res_sh <= res_nx;
                    cnt    <= cnt - CNT_W'(1);
                    if (last_digit) begin
                        Diff <= res_nx;
                        Bout <= ~cout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;

    // Keep the original sign bits; overflow when signs differ and the result sign flips from A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_msb <= A[WIDTH-1];
                b_msb <= B[WIDTH-1];
            end
            if (state == RUN && last_digit)
                overflow <= (a_msb != b_msb) && (res_nx[WIDTH-1] != a_msb);
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic model + per-cycle monitor
// plus directed vectors with literal expectations.
module tb_serial_subtractor;

    localparam int W = 32;
`ifdef SERIAL_SUB_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         Bin = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] Diff;
    logic         Bout;
    logic         overflow;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           acc;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] last_d = '0;
    logic         last_bo = 1'b0;
    logic         last_ov = 1'b0;

    serial_subtractor #(.WIDTH(W), .DIGIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Plain arithmetic: modular difference, unsigned compare, signed range test.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic bin, input int acc);
        exp_t   e;
        longint ua, ub, sa, sb, sd;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sd = sa - sb - longint'(bin);
        e.d   = W'(ua - ub - longint'(bin));
        e.bo  = (ua < ub + longint'(bin));
        e.ov  = OVF_EN && ((sd > 64'sd2147483647) || (sd < -64'sd2147483648));
        e.acc = acc;
        return e;
    endfunction

    // Monitor: every cycle, compare DUT against the model's pending queue.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            last_d  = '0;
            last_bo = 1'b0;
            last_ov = 1'b0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_diff", Diff, 0);
            chk("rst_bout", Bout, 0);
            chk("rst_ovf", overflow, 0);
        end else begin
            chk("in_ready", in_ready, q.size() == 0);
            if (q.size() == 0) chk("out_valid_idle", out_valid, 0);
            else               chk("out_valid_latency", out_valid, cyc >= q[0].acc + 9);
            if (out_valid && q.size() > 0) begin
                chk("mdl_diff", Diff, q[0].d);
                chk("mdl_bout", Bout, q[0].bo);
                chk("mdl_ovf", overflow, q[0].ov);
                if (out_ready) begin
                    last_d  = q[0].d;
                    last_bo = q[0].bo;
                    last_ov = q[0].ov;
                    void'(q.pop_front());
                end
            end else if (!out_valid) begin
                chk("held_diff", Diff, last_d);
                chk("held_bout", Bout, last_bo);
                chk("held_ovf", overflow, last_ov);
            end
            if (in_valid && in_ready) q.push_back(model(A, B, Bin, cyc));
        end
    end

    // One transaction with literal expectations; eo is the overflow when the feature is on.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                      input logic [W-1:0] ed, input logic eb, input logic eo,
                      input bit scramble, input int stall);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        chk("accept_wait", in_ready, 1);
        A = a; B = b; Bin = bin; in_valid = 1'b1;
        if (stall > 0) out_ready = 1'b0;
        @(posedge clk); #2;
        in_valid = 1'b0;
        if (scramble) begin
            A = 32'h0000FFFF; B = '0; Bin = 1'b1;
        end
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        chk("result_wait", out_valid, 1);
        if (out_valid) begin
            chk("lit_diff", Diff, ed);
            chk("lit_bout", Bout, eb);
            chk("lit_ovf", overflow, OVF_EN ? eo : 1'b0);
            if (stall > 0) begin
                repeat (stall) begin
                    @(posedge clk); #2;
                    chk("bp_valid", out_valid, 1);
                    chk("bp_diff", Diff, ed);
                    chk("bp_bout", Bout, eb);
                    chk("bp_in_ready", in_ready, 0);
                end
                out_ready = 1'b1;
                @(posedge clk); #2;
                chk("bp_release_ready", in_ready, 1);
                chk("bp_release_valid", out_valid, 0);
            end else begin
                @(posedge clk); #2;
                chk("post_hs_ready", in_ready, 1);
            end
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        op(32'd5,          32'd3,          1'b0, 32'h00000002, 1'b0, 1'b0, 0, 0);
        op(32'd10,         32'd3,          1'b1, 32'h00000006, 1'b0, 1'b0, 0, 0);
        op(32'd0,          32'd1,          1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 0, 0);
        op(32'h80000000,   32'd1,          1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 0, 0);
        op(32'h7FFFFFFF,   32'hFFFFFFFF,   1'b0, 32'h80000000, 1'b1, 1'b1, 0, 0);
        op(32'h12345678,   32'h12345678,   1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 0, 0);
        op(32'h80000000,   32'd0,          1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 0, 0);
        op(32'd5,          32'd3,          1'b0, 32'h00000002, 1'b0, 1'b0, 0, 5);
        op(32'd5,          32'd3,          1'b0, 32'h00000002, 1'b0, 1'b0, 1, 0);

        // Abort a transaction mid-RUN with reset.
        A = 32'd5; B = 32'd7; Bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_diff", Diff, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        op(32'd100,        32'd58,         1'b0, 32'd42,       1'b0, 1'b0, 0, 0);

        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
